// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial nibble receiver.
package serial_rx_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 1 (line idle).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_nibble_rx.sv
// Serial receiver for start + 4 data bits (LSB first) + optional even parity + stop frames.
module serial_nibble_rx
    import serial_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    output logic [NIBBLE_W-1:0] data,
    output logic                valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLoad = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);

    logic rx_s;

    rx_state_t           state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          bit_q, bit_d;
    logic [NIBBLE_W-1:0] shift_q, shift_d;
    logic [NIBBLE_W-1:0] data_q, data_d;
    logic                perr_q, perr_d;
    logic                valid_q, valid_d;
    logic                perr_stb_q, perr_stb_d;
    logic                ferr_q, ferr_d;
    logic                sample;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    assign sample = (cnt_q == '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        perr_d     = perr_q;
        valid_d    = 1'b0;
        perr_stb_d = 1'b0;
        ferr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    state_d = StStart;
                    cnt_d   = HalfLoad;
                end
            end
            StStart: begin
                if (!sample) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_s) begin
                    state_d = StIdle;
                end else begin
                    state_d = StData;
                    cnt_d   = FullLoad;
                    bit_d   = 2'd0;
                    perr_d  = 1'b0;
                end
            end
            StData: begin
                if (!sample) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Shift in from the top so bit 0 ends up at shift_q[0].
                    shift_d = {rx_s, shift_q[NIBBLE_W-1:1]};
                    cnt_d   = FullLoad;
                    bit_d   = bit_q + 2'd1;
                    if (bit_q == 2'd3) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
            end
            StParity: begin
                if (!sample) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    perr_d  = (^shift_q) ^ rx_s;
                    state_d = StStop;
                    cnt_d   = FullLoad;
                end
            end
            StStop: begin
                if (!sample) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (!rx_s) begin
                    ferr_d  = 1'b1;
                    state_d = StBreak;
                end else if (perr_q) begin
                    perr_stb_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    state_d = StIdle;
                end
            end
            StBreak: begin
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            valid_q    <= 1'b0;
            perr_stb_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            valid_q    <= valid_d;
            perr_stb_q <= perr_stb_d;
            ferr_q     <= ferr_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_stb_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_nibble_rx.sv
// Directed bench: one receiver with parity, one without, sharing clock and reset.
module tb_serial_nibble_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_p = 1'b1;
    logic       rx_n = 1'b1;
    logic [3:0] data_p, data_n;
    logic       valid_p, valid_n, perr_p, perr_n, ferr_p, ferr_n, busy_p, busy_n;

    int checks = 0;
    int errors = 0;

    int         v_cnt_p = 0, v_cnt_n = 0, pe_cnt = 0, fe_cnt = 0, bad_cnt = 0;
    logic [3:0] hist_p [16];
    logic [3:0] hist_n [16];
    logic       any_prev_p = 1'b0;

    always #5 clk = ~clk;

    serial_nibble_rx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_p (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_p),
        .data       (data_p),
        .valid      (valid_p),
        .parity_err (perr_p),
        .frame_err  (ferr_p),
        .busy       (busy_p)
    );

    serial_nibble_rx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0)) dut_n (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_n),
        .data       (data_n),
        .valid      (valid_n),
        .parity_err (perr_n),
        .frame_err  (ferr_n),
        .busy       (busy_n)
    );

    // Strobe monitor; also flags overlapping or back-to-back strobes.
    always @(negedge clk) begin
        if (valid_p) begin
            hist_p[v_cnt_p % 16] <= data_p;
            v_cnt_p <= v_cnt_p + 1;
        end
        if (valid_n) begin
            hist_n[v_cnt_n % 16] <= data_n;
            v_cnt_n <= v_cnt_n + 1;
        end
        if (perr_p) pe_cnt <= pe_cnt + 1;
        if (ferr_p) fe_cnt <= fe_cnt + 1;
        if ((int'(valid_p) + int'(perr_p) + int'(ferr_p) > 1) ||
            ((valid_p | perr_p | ferr_p) && any_prev_p) ||
            perr_n || ferr_n)
            bad_cnt <= bad_cnt + 1;
        any_prev_p <= valid_p | perr_p | ferr_p;
    end

    task automatic drive_bit(input bit which, input logic b);
        if (which) rx_n = b;
        else rx_p = b;
        repeat (4) @(negedge clk);
    endtask

    // Must be called on a negedge; returns on the negedge where the stop bit ends.
    task automatic send_frame(input bit which, input logic [3:0] nib, input logic par,
                              input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(which, nib[i]);
        if (!which) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (data_p !== 4'h0) begin errors++;
            $display("FAIL reset_data got %h want 0", data_p); end
        checks++; if ({valid_p, perr_p, ferr_p, busy_p} !== 4'b0) begin errors++;
            $display("FAIL reset_flags got %b want 0000", {valid_p, perr_p, ferr_p, busy_p}); end
        checks++; if ({data_n, valid_n, perr_n, ferr_n, busy_n} !== 8'h00) begin errors++;
            $display("FAIL reset_np got %h want 00", {data_n, valid_n, perr_n, ferr_n, busy_n}); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good();
        int v0 = v_cnt_p, pe0 = pe_cnt, fe0 = fe_cnt;
        send_frame(1'b0, 4'hA, 1'b0, 1'b1);
        checks++; if (valid_p !== 1'b0) begin errors++;
            $display("FAIL good_early_valid got %b want 0", valid_p); end
        @(negedge clk);
        checks++; if (valid_p !== 1'b1) begin errors++;
            $display("FAIL good_latency valid got %b want 1", valid_p); end
        checks++; if (data_p !== 4'hA) begin errors++;
            $display("FAIL good_data got %h want a", data_p); end
        repeat (8) @(negedge clk);
        checks++; if (v_cnt_p - v0 !== 1) begin errors++;
            $display("FAIL good_valid_count got %0d want 1", v_cnt_p - v0); end
        checks++; if ((pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin errors++;
            $display("FAIL good_errors got %0d want 0", (pe_cnt - pe0) + (fe_cnt - fe0)); end
        checks++; if (busy_p !== 1'b0) begin errors++;
            $display("FAIL good_busy got %b want 0", busy_p); end
    endtask

    task automatic test_parity();
        int v0 = v_cnt_p, pe0 = pe_cnt;
        send_frame(1'b0, 4'h7, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (pe_cnt - pe0 !== 1) begin errors++;
            $display("FAIL parity_err_count got %0d want 1", pe_cnt - pe0); end
        checks++; if (v_cnt_p - v0 !== 0) begin errors++;
            $display("FAIL parity_valid_count got %0d want 0", v_cnt_p - v0); end
        checks++; if (data_p !== 4'hA) begin errors++;
            $display("FAIL parity_data_kept got %h want a", data_p); end
    endtask

    task automatic test_frame();
        int v0 = v_cnt_p, pe0 = pe_cnt, fe0 = fe_cnt;
        send_frame(1'b0, 4'h3, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (busy_p !== 1'b1) begin errors++;
            $display("FAIL frame_busy_held got %b want 1", busy_p); end
        checks++; if (fe_cnt - fe0 !== 1) begin errors++;
            $display("FAIL frame_err_count got %0d want 1", fe_cnt - fe0); end
        checks++; if ((v_cnt_p - v0) + (pe_cnt - pe0) !== 0) begin errors++;
            $display("FAIL frame_other_strobes got %0d want 0", (v_cnt_p - v0) + (pe_cnt - pe0)); end
        rx_p = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy_p !== 1'b0) begin errors++;
            $display("FAIL frame_break_exit busy got %b want 0", busy_p); end
        checks++; if (fe_cnt - fe0 !== 1 || data_p !== 4'hA) begin errors++;
            $display("FAIL frame_after got fe %0d data %h want 1 a", fe_cnt - fe0, data_p); end
    endtask

    task automatic test_glitch();
        int v0 = v_cnt_p, pe0 = pe_cnt, fe0 = fe_cnt;
        rx_p = 1'b0;
        @(negedge clk);
        rx_p = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if ((v_cnt_p - v0) + (pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin errors++;
            $display("FAIL glitch_strobes got %0d want 0",
                     (v_cnt_p - v0) + (pe_cnt - pe0) + (fe_cnt - fe0)); end
        checks++; if (busy_p !== 1'b0 || data_p !== 4'hA) begin errors++;
            $display("FAIL glitch_state got busy %b data %h want 0 a", busy_p, data_p); end
    endtask

    task automatic test_reset_mid();
        int v0 = v_cnt_p;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        rx_p = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_p = 1'b1;
        @(negedge clk);
        checks++; if ({data_p, valid_p, perr_p, ferr_p, busy_p} !== 8'h00) begin errors++;
            $display("FAIL midreset_outputs got %h want 00",
                     {data_p, valid_p, perr_p, ferr_p, busy_p}); end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (v_cnt_p - v0 !== 0 || busy_p !== 1'b0) begin errors++;
            $display("FAIL midreset_discard got %0d busy %b want 0 0", v_cnt_p - v0, busy_p); end
        send_frame(1'b0, 4'h5, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (v_cnt_p - v0 !== 1 || data_p !== 4'h5) begin errors++;
            $display("FAIL midreset_frame got %0d data %h want 1 5", v_cnt_p - v0, data_p); end
    endtask

    task automatic test_back_to_back();
        int vp = v_cnt_p, vn = v_cnt_n;
        send_frame(1'b0, 4'h3, 1'b0, 1'b1);
        send_frame(1'b0, 4'hC, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (v_cnt_p - vp !== 2) begin errors++;
            $display("FAIL b2b_p_count got %0d want 2", v_cnt_p - vp); end
        checks++; if (hist_p[vp % 16] !== 4'h3 || hist_p[(vp + 1) % 16] !== 4'hC) begin errors++;
            $display("FAIL b2b_p_data got %h %h want 3 c", hist_p[vp % 16],
                     hist_p[(vp + 1) % 16]); end
        send_frame(1'b1, 4'h3, 1'b0, 1'b1);
        send_frame(1'b1, 4'hC, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        checks++; if (v_cnt_n - vn !== 2) begin errors++;
            $display("FAIL b2b_np_count got %0d want 2", v_cnt_n - vn); end
        checks++; if (hist_n[vn % 16] !== 4'h3 || hist_n[(vn + 1) % 16] !== 4'hC) begin errors++;
            $display("FAIL b2b_np_data got %h %h want 3 c", hist_n[vn % 16],
                     hist_n[(vn + 1) % 16]); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_good();
        test_parity();
        test_frame();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        checks++; if (bad_cnt !== 0) begin errors++;
            $display("FAIL strobe_exclusive got %0d want 0", bad_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_nibble_rx.md
SERIAL_NIBBLE_RX -- requirements
Module: serial_nibble_rx

Interface
Parameters:
REQ-001 CLKS_PER_BIT, 4, clocks per serial bit period; SHALL be an integer >= 2.
REQ-002 PARITY_EN, 1, 1 = an even-parity bit follows the data bits; 0 = no parity bit.
Ports:
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 data  output  4  last correctly received nibble; feeds the downstream 4-bit register's D input.
REQ-007 valid  output  1  one-cycle strobe when data updates; drives the downstream register's enable.
REQ-008 parity_err  output  1  one-cycle strobe on a parity mismatch.
REQ-009 frame_err  output  1  one-cycle strobe when the stop bit is sampled low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all logic below SHALL use only the synchronized rx_s.
REQ-012 Frame format SHALL be: start (0), 4 data bits LSB first, parity (only when PARITY_EN=1), stop (1).
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-014 In IDLE, rx_s==0 SHALL move the FSM to START and load the bit counter so that the start bit is re-sampled CLKS_PER_BIT/2 (integer division) clocks later.
REQ-015 At the START sample point: if rx_s==1 (glitch), the FSM SHALL return to IDLE with no strobe; otherwise it SHALL enter DATA.
REQ-016 Each later sample SHALL occur exactly CLKS_PER_BIT clocks after the previous sample.
REQ-017 DATA SHALL take 4 samples into a shift register, bit 0 first, then go to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-018 PARITY SHALL record a mismatch when (XOR of the 4 data bits) XOR the parity bit is 1.
REQ-019 At the STOP sample with rx_s==1 and no parity mismatch, on the next clock: data <= shifted nibble, valid=1 for one cycle, and the FSM returns to IDLE.
REQ-020 At the STOP sample with rx_s==1 and a parity mismatch, on the next clock: parity_err=1 for one cycle; data SHALL NOT change; the FSM returns to IDLE.
REQ-021 At the STOP sample with rx_s==0, on the next clock: frame_err=1 for one cycle (it takes precedence; parity_err=0); data SHALL NOT change; the FSM enters BREAK.
REQ-022 BREAK SHALL ignore the line until rx_s==1, then return to IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-023 valid, parity_err and frame_err SHALL be mutually exclusive and SHALL never be high for two consecutive cycles from one frame.
REQ-024 A new start bit SHALL be accepted the first IDLE cycle after the previous frame ends (back-to-back frames, no idle bit required).
REQ-025 Latency from the stop-bit sample to valid SHALL be exactly 1 clock.

Reset
REQ-026 reset=0 SHALL immediately force: FSM=IDLE, data=4'h0, valid=0, parity_err=0, frame_err=0, busy=0, counters=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame with no strobe; after release the block SHALL wait for a fresh falling edge.

Structure
REQ-028 Package serial_rx_pkg SHALL hold the FSM state enum (rx_state_t) and the constant NIBBLE_W=4.
REQ-029 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value 1); everything else SHALL be in serial_nibble_rx.

Verification (CLKS_PER_BIT=4, PARITY_EN=1 unless stated)
REQ-030 Frame for 4'hA (bits 0,1,0,1, parity 0, stop 1) -> data=4'hA, one valid pulse, no errors.
REQ-031 Frame for 4'h7 with parity bit 0 -> parity_err pulse, valid=0, data keeps its previous value.
REQ-032 Frame for 4'h3 with stop bit 0, then rx held low for 40 clocks -> one frame_err pulse, busy stays high, no further strobes until rx returns high.
REQ-033 rx low for 1 clock only -> FSM returns to IDLE, no strobe, data unchanged.
REQ-034 reset pulsed low during the 2nd data bit, then a full frame for 4'h5 -> outputs zero during reset, then data=4'h5 with one valid pulse.
REQ-035 Back-to-back frames 4'h3 then 4'hC with no idle gap, also run with PARITY_EN=0 -> two valid pulses with data 4'h3 then 4'hC.
